// File: rtl/fixed_point_pkg.sv
// Shared fixed-point helpers for the subtractor/adder family: format sizing,
// saturation constants and overflow-check width.
package fixed_point_pkg;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Largest positive two's-complement value of width w: 0 followed by all 1s.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of width w: 1 followed by all 0s.
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

  // Number of integer MSBs dropped when narrowing il+1 integer bits to wio.
  function automatic int ovf_check_width(input int wio, input int il);
    return (il + 1 > wio) ? (il + 1 - wio) : 0;
  endfunction

endpackage

// File: rtl/fixed_point_rescale.sv
// Combinational conversion of an exact (IL+1).FL value to WIO.WFO with
// overflow detection and optional saturation.
module fixed_point_rescale import fixed_point_pkg::*; #(
  parameter int IL  = 4,
  parameter int FL  = 4,
  parameter int WIO = 5,
  parameter int WFO = 4,
  parameter int SAT = 0
) (
  input  logic [IL+FL:0]      d_in,
  output logic [WIO+WFO-1:0]  d_out,
  output logic                ovf
);

  localparam int DW   = IL + FL + 1;
  localparam int WO   = WIO + WFO;
  localparam int SHL  = (WFO >= FL) ? (WFO - FL) : 0;
  localparam int SHR  = (WFO >= FL) ? 0 : (FL - WFO);
  localparam int WW   = DW + SHL + WO;
  localparam int NCHK = ovf_check_width(WIO, IL);

  localparam logic [WO-1:0] MAXV = WO'(sat_max(WO));
  localparam logic [WO-1:0] MINV = WO'(sat_min(WO));

  logic signed [WW-1:0] ext;
  logic [WO-1:0]        wrap;
  logic [NCHK:0]        chk;

  always_comb begin
    ext  = $signed({{(WW - DW){d_in[DW-1]}}, d_in});
    // Arithmetic right shift drops fraction LSBs, i.e. truncates toward -inf.
    wrap = WO'((ext <<< SHL) >>> SHR);
    // Dropped MSBs plus the new sign bit must all agree for the value to fit.
    chk  = d_in[DW-1 -: NCHK + 1];
    ovf  = !((chk == '0) || (chk == '1));
    if ((SAT != 0) && ovf) begin
      d_out = d_in[DW-1] ? MINV : MAXV;
    end else begin
      d_out = wrap;
    end
  end

endmodule

// File: rtl/fixed_point_subtractor.sv
// Two-stage valid/ready fixed-point subtractor: out_diff = in1 - in2,
// aligned exactly in stage 1 and rescaled to WIO.WFO in stage 2.
module fixed_point_subtractor import fixed_point_pkg::*; #(
  parameter int WI1 = 3,
  parameter int WF1 = 4,
  parameter int WI2 = 4,
  parameter int WF2 = 3,
  parameter int WIO = max_int(WI1, WI2) + 1,
  parameter int WFO = max_int(WF1, WF2),
  parameter int SAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WI1+WF1-1:0]   in1,
  input  logic [WI2+WF2-1:0]   in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIO+WFO-1:0]   out_diff,
  output logic                 out_ovf,
  input  logic                 ovf_clr,
  output logic                 ovf_sticky
);

  localparam int IL = max_int(WI1, WI2);
  localparam int FL = max_int(WF1, WF2);
  localparam int DW = IL + FL + 1;
  localparam int WO = WIO + WFO;

  logic              s1_valid_q, s1_valid_d;
  logic [DW-1:0]     s1_diff_q, s1_diff_d;
  logic              out_valid_q, out_valid_d;
  logic [WO-1:0]     out_diff_q, out_diff_d;
  logic              out_ovf_q, out_ovf_d;
  logic              ovf_sticky_q, ovf_sticky_d;

  logic signed [DW-1:0] a1, a2;
  logic [WO-1:0]        resc_diff;
  logic                 resc_ovf;
  logic                 s2_load, s1_adv, s1_load;

  fixed_point_rescale #(
    .IL  (IL),
    .FL  (FL),
    .WIO (WIO),
    .WFO (WFO),
    .SAT (SAT)
  ) u_rescale (
    .d_in  (s1_diff_q),
    .d_out (resc_diff),
    .ovf   (resc_ovf)
  );

  always_comb begin
    a1 = DW'($signed(in1)) <<< (FL - WF1);
    a2 = DW'($signed(in2)) <<< (FL - WF2);

    s2_load  = !out_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_load;
    in_ready = !rst && (!s1_valid_q || s1_adv);
    s1_load  = in_valid && in_ready;

    s1_valid_d = s1_load || (s1_valid_q && !s1_adv);
    s1_diff_d  = s1_load ? DW'(a1 - a2) : s1_diff_q;

    out_valid_d = s1_adv || (out_valid_q && !out_ready);
    out_diff_d  = s1_adv ? resc_diff : out_diff_q;
    out_ovf_d   = s1_adv ? resc_ovf  : out_ovf_q;

    // A consumed overflow takes priority over a clear in the same cycle.
    if (out_valid_q && out_ready && out_ovf_q) begin
      ovf_sticky_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky_d = 1'b0;
    end else begin
      ovf_sticky_d = ovf_sticky_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_diff_q    <= '0;
      out_valid_q  <= 1'b0;
      out_diff_q   <= '0;
      out_ovf_q    <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_diff_q    <= s1_diff_d;
      out_valid_q  <= out_valid_d;
      out_diff_q   <= out_diff_d;
      out_ovf_q    <= out_ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_diff   = out_diff_q;
  assign out_ovf    = out_ovf_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_fixed_point_subtractor.sv
// Bench for fixed_point_subtractor: four output-format variants driven in
// lockstep and checked against an arithmetic reference model.
module tb_fixed_point_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready, ovf_clr;
  logic [6:0] in1, in2;

  logic       rdy_def, rdy_sat, rdy_wrap, rdy_tr;
  logic       v_def, v_sat, v_wrap, v_tr;
  logic [8:0] d_def;
  logic [6:0] d_sat, d_wrap, d_tr;
  logic       o_def, o_sat, o_wrap, o_tr;
  logic       s_def, s_sat, s_wrap, s_tr;

  always #5 clk = ~clk;

  fixed_point_subtractor u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_def), .in1(in1), .in2(in2),
    .out_valid(v_def), .out_ready(out_ready), .out_diff(d_def), .out_ovf(o_def),
    .ovf_clr(ovf_clr), .ovf_sticky(s_def));

  fixed_point_subtractor #(.WIO(3), .WFO(4), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_sat), .in1(in1), .in2(in2),
    .out_valid(v_sat), .out_ready(out_ready), .out_diff(d_sat), .out_ovf(o_sat),
    .ovf_clr(ovf_clr), .ovf_sticky(s_sat));

  fixed_point_subtractor #(.WIO(3), .WFO(4), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_wrap), .in1(in1), .in2(in2),
    .out_valid(v_wrap), .out_ready(out_ready), .out_diff(d_wrap), .out_ovf(o_wrap),
    .ovf_clr(ovf_clr), .ovf_sticky(s_wrap));

  fixed_point_subtractor #(.WIO(5), .WFO(2)) u_tr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_tr), .in1(in1), .in2(in2),
    .out_valid(v_tr), .out_ready(out_ready), .out_diff(d_tr), .out_ovf(o_tr),
    .ovf_clr(ovf_clr), .ovf_sticky(s_tr));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // in1 is Q3.4, in2 is Q4.3; the difference is held in units of 1/16.
  function automatic int model(input logic [6:0] a, input logic [6:0] b,
                               input int wio, input int wfo, input int sat,
                               output logic ovf);
    int d, r, hi, lo;
    d = int'($signed(a)) - 2 * int'($signed(b));
    if (wfo >= 4) r = d * (1 << (wfo - 4));
    else          r = d >>> (4 - wfo);
    hi  = (1 << (wio + wfo - 1)) - 1;
    lo  = -(1 << (wio + wfo - 1));
    ovf = (r > hi) || (r < lo);
    if (ovf && (sat != 0)) r = (d > 0) ? hi : lo;
    return r & ((1 << (wio + wfo)) - 1);
  endfunction

  typedef struct {
    logic [6:0] a;
    logic [6:0] b;
    int         acc;
  } item_t;

  item_t      sb[$];
  int         cyc = 0;
  logic       stick = 1'b0;
  logic       rst_seen = 1'b0;
  logic       hold = 1'b0;
  logic [8:0] h_def;
  logic [6:0] h_sat, h_wrap, h_tr;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare against the model: occupancy drives expected valid/ready.
  always @(negedge clk) begin
    item_t e;
    logic  exp_v, exp_r, ov_def, ov_sat, ov_wrap, ov_tr;
    int    x_def, x_sat, x_wrap, x_tr;
    if (rst_seen) begin
      chk("rst_diff_def", int'(d_def), 0);
      chk("rst_diff_sat", int'(d_sat), 0);
      chk("rst_ovf_sat", int'(o_sat), 0);
    end
    if (rst) begin
      chk("in_ready_in_rst", int'(rdy_def), 0);
      sb.delete();
      stick    = 1'b0;
      hold     = 1'b0;
      rst_seen = 1'b1;
    end else begin
      rst_seen = 1'b0;
      exp_v = (sb.size() > 0) && (sb[0].acc < cyc);
      exp_r = !((sb.size() == 2) && !out_ready);
      chk("in_ready", int'(rdy_def), int'(exp_r));
      chk("in_ready_sat", int'(rdy_sat), int'(exp_r));
      chk("out_valid_def", int'(v_def), int'(exp_v));
      chk("out_valid_sat", int'(v_sat), int'(exp_v));
      chk("out_valid_wrap", int'(v_wrap), int'(exp_v));
      chk("out_valid_tr", int'(v_tr), int'(exp_v));
      chk("sticky_sat", int'(s_sat), int'(stick));
      chk("sticky_wrap", int'(s_wrap), int'(stick));
      chk("sticky_def", int'(s_def), 0);
      if (hold) begin
        chk("hold_def", int'(d_def), int'(h_def));
        chk("hold_sat", int'(d_sat), int'(h_sat));
        chk("hold_wrap", int'(d_wrap), int'(h_wrap));
        chk("hold_tr", int'(d_tr), int'(h_tr));
      end
      if (exp_v && out_ready) begin
        e      = sb.pop_front();
        x_def  = model(e.a, e.b, 5, 4, 0, ov_def);
        x_sat  = model(e.a, e.b, 3, 4, 1, ov_sat);
        x_wrap = model(e.a, e.b, 3, 4, 0, ov_wrap);
        x_tr   = model(e.a, e.b, 5, 2, 0, ov_tr);
        chk("diff_def", int'(d_def), x_def);
        chk("diff_sat", int'(d_sat), x_sat);
        chk("diff_wrap", int'(d_wrap), x_wrap);
        chk("diff_tr", int'(d_tr), x_tr);
        chk("ovf_def", int'(o_def), int'(ov_def));
        chk("ovf_sat", int'(o_sat), int'(ov_sat));
        chk("ovf_wrap", int'(o_wrap), int'(ov_wrap));
        chk("ovf_tr", int'(o_tr), int'(ov_tr));
        if (ov_sat) stick = 1'b1;
        else if (ovf_clr) stick = 1'b0;
      end else if (ovf_clr) begin
        stick = 1'b0;
      end
      hold   = exp_v && !out_ready;
      h_def  = d_def;
      h_sat  = d_sat;
      h_wrap = d_wrap;
      h_tr   = d_tr;
      if (in_valid && rdy_def) sb.push_back('{a: in1, b: in2, acc: cyc + 1});
    end
  end

  // Present one pair into an empty pipeline, check the 2-cycle latency and the
  // hand-computed results, optionally pulsing ovf_clr as the result is taken.
  task automatic directed(input logic [6:0] a, input logic [6:0] b,
                          input int e_def, input int e_sat, input int e_wrap, input int e_tr,
                          input logic e_ovf, input logic clr);
    @(posedge clk); #1;
    in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b1;
    chk("dir_in_ready", int'(rdy_def), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("dir_lat1_valid", int'(v_def), 0);
    @(posedge clk); #1;
    chk("dir_lat2_valid", int'(v_def), 1);
    chk("dir_def", int'(d_def), e_def);
    chk("dir_sat", int'(d_sat), e_sat);
    chk("dir_wrap", int'(d_wrap), e_wrap);
    chk("dir_tr", int'(d_tr), e_tr);
    chk("dir_ovf_sat", int'(o_sat), int'(e_ovf));
    chk("dir_ovf_def", int'(o_def), 0);
    ovf_clr = clr;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    if (e_ovf) chk("dir_sticky_set_wins", int'(s_sat), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int   c, sent, delivered;
    logic stall, acc, dl, saw_stall;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    in1 = '0; in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(v_def), 0);
    chk("rst_sticky", int'(s_sat), 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", int'(rdy_def), 1);

    directed(7'h18, 7'h02, 'h014, 'h14, 'h14, 'h05, 1'b0, 1'b0);
    directed(7'h60, 7'h0C, 'h1C8, 'h48, 'h48, 'h72, 1'b0, 1'b0);
    directed(7'h3F, 7'h78, 'h04F, 'h3F, 'h4F, 'h13, 1'b1, 1'b1);
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    chk("sticky_cleared", int'(s_sat), 0);
    directed(7'h3F, 7'h78, 'h04F, 'h3F, 'h4F, 'h13, 1'b1, 1'b0);
    directed(7'h7F, 7'h00, 'h1FF, 'h7F, 'h7F, 'h7F, 1'b0, 1'b0);

    // Six-pair burst with the consumer stalled in cycles 2-4.
    c = 0; sent = 0; delivered = 0; saw_stall = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in1 = 7'($urandom); in2 = 7'($urandom); out_ready = 1'b1;
    while (delivered < 6 && c < 40) begin
      @(negedge clk);
      acc = in_valid && rdy_def;
      dl  = v_def && out_ready;
      if (!rdy_def) saw_stall = 1'b1;
      @(posedge clk); #1;
      c++;
      if (acc) sent++;
      if (dl) delivered++;
      out_ready = !(c >= 2 && c <= 4);
      if (sent >= 6) in_valid = 1'b0;
      else if (acc) begin
        in1 = 7'($urandom); in2 = 7'($urandom);
      end
    end
    chk("burst_delivered", delivered, 6);
    chk("burst_saw_backpressure", int'(saw_stall), 1);
    chk("burst_in_budget", int'(c < 40), 1);

    // Reset with two pairs in flight; ensure sticky is set first.
    directed(7'h3F, 7'h78, 'h04F, 'h3F, 'h4F, 'h13, 1'b1, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in1 = 7'h18; in2 = 7'h02;
    @(posedge clk); #1;
    in1 = 7'h3F; in2 = 7'h78;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("inflight_valid", int'(v_def), 1);
    rst = 1'b1;
    #1;
    chk("in_ready_rst_comb", int'(rdy_def), 0);
    @(posedge clk); #1;
    chk("midrst_valid", int'(v_def), 0);
    chk("midrst_diff", int'(d_def), 0);
    chk("midrst_ovf", int'(o_sat), 0);
    chk("midrst_sticky", int'(s_sat), 0);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("midrst_in_ready_after", int'(rdy_def), 1);

    // Randomized traffic; the producer holds its pair while stalled.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      stall = in_valid && !rdy_def;
      @(posedge clk); #1;
      if (!stall) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in1 = 7'($urandom);
        in2 = 7'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    stall = in_valid && !rdy_def;
    @(posedge clk); #1;
    if (!stall) in_valid = 1'b0;
    out_ready = 1'b1; ovf_clr = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
